// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Size and state encodings are fixed two-bit codes used on the request bus.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    ERR  = 2'b11
  } state_e;

  // rr_last starts at 1 so port 0 wins the first contention
  localparam logic RR_RESET = 1'b1;

  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; byte 0 of a word is its most significant byte.
module dmem_lane_unit
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // lane extraction from the addressed word
  always_comb begin
    case (addr)
      2'b00:   byte_s = word[31:24];
      2'b01:   byte_s = word[23:16];
      2'b10:   byte_s = word[15:8];
      default: byte_s = word[7:0];
    endcase
    if (addr[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
  end

  // sign or zero extension of the selected lane
  always_comb begin
    case (size)
      SZ_B:    load_ext = zext ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_H:    load_ext = zext ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default: load_ext = word;
    endcase
  end

  // replace the addressed lane(s) of the old word with right-justified store data
  always_comb begin
    merged = word;
    case (size)
      SZ_B: begin
        case (addr)
          2'b00:   merged[31:24] = wdata[7:0];
          2'b01:   merged[23:16] = wdata[7:0];
          2'b10:   merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr[1]) begin
          merged[15:0] = wdata[15:0];
        end else begin
          merged[31:16] = wdata[15:0];
        end
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin arbiter and access sequencer in front of a big-endian data memory.
// Sub-word stores run as read-modify-write; illegal accesses are answered without strobes.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic        req_we0,
  input  logic        req_we1,
  input  logic [1:0]  req_size0,
  input  logic [1:0]  req_size1,
  input  logic        req_unsigned0,
  input  logic        req_unsigned1,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_r;
  logic        rr_last_r;
  logic        owner_r;
  logic        we_r;
  logic        unsigned_r;
  size_e       size_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] wdata_r;
  logic [31:0] merged_r;
  logic [31:0] mem_addr_r;
  logic [1:0]  rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        grant_s;
  logic        gidx_s;
  logic        sel_we_s;
  logic        sel_uns_s;
  size_e       sel_size_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        misalign_s;
  logic [32:0] end_addr_s;
  logic        bad_s;
  logic [31:0] load_ext_s;
  logic [31:0] merged_s;
  logic [31:0] mem_wdata_s;

  // arbitration: single requester wins outright, contention goes to the port != rr_last
  always_comb begin
    grant_s = 1'b0;
    gidx_s  = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      case (req_valid)
        2'b01: begin
          grant_s = 1'b1;
          gidx_s  = 1'b0;
        end
        2'b10: begin
          grant_s = 1'b1;
          gidx_s  = 1'b1;
        end
        2'b11: begin
          grant_s = 1'b1;
          gidx_s  = ~rr_last_r;
        end
        default: begin
          grant_s = 1'b0;
          gidx_s  = 1'b0;
        end
      endcase
    end else begin
      grant_s = 1'b0;
      gidx_s  = 1'b0;
    end
  end

  assign req_ready = grant_s ? {gidx_s, ~gidx_s} : 2'b00;

  // request field mux for the granted port
  always_comb begin
    if (gidx_s) begin
      sel_we_s    = req_we1;
      sel_uns_s   = req_unsigned1;
      sel_size_s  = size_e'(req_size1);
      sel_addr_s  = req_addr1;
      sel_wdata_s = req_wdata1;
    end else begin
      sel_we_s    = req_we0;
      sel_uns_s   = req_unsigned0;
      sel_size_s  = size_e'(req_size0);
      sel_addr_s  = req_addr0;
      sel_wdata_s = req_wdata0;
    end
  end

  // legality: size code, natural alignment and end address computed without wrap
  always_comb begin
    end_addr_s = {1'b0, sel_addr_s} + {30'd0, size_bytes(sel_size_s)};
    case (sel_size_s)
      SZ_B:    misalign_s = 1'b0;
      SZ_H:    misalign_s = sel_addr_s[0];
      SZ_W:    misalign_s = |sel_addr_s[1:0];
      default: misalign_s = 1'b1;
    endcase
    bad_s = misalign_s | (end_addr_s > 33'(MEM_BYTES));
  end

  dmem_lane_unit u_lane (
    .word     (mem_rdata),
    .addr     (addr_lo_r),
    .size     (size_r),
    .zext     (unsigned_r),
    .wdata    (wdata_r),
    .load_ext (load_ext_s),
    .merged   (merged_s)
  );

  // access sequencer with registered responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_last_r   <= RR_RESET;
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      unsigned_r  <= 1'b0;
      size_r      <= SZ_B;
      addr_lo_r   <= 2'b00;
      wdata_r     <= 32'd0;
      merged_r    <= 32'd0;
      mem_addr_r  <= 32'd0;
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r    <= gidx_s;
            rr_last_r  <= gidx_s;
            we_r       <= sel_we_s;
            unsigned_r <= sel_uns_s;
            size_r     <= sel_size_s;
            addr_lo_r  <= sel_addr_s[1:0];
            wdata_r    <= sel_wdata_s;
            if (bad_s) begin
              state_r <= ERR;
            end else begin
              mem_addr_r <= {sel_addr_s[31:2], 2'b00};
              state_r    <= (sel_we_s && (sel_size_s == SZ_W)) ? WR : RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          if (we_r) begin
            merged_r <= merged_s;
            state_r  <= WR;
          end else begin
            rsp_valid_r <= {owner_r, ~owner_r};
            rsp_rdata_r <= load_ext_s;
            state_r     <= IDLE;
          end
        end
        WR: begin
          rsp_valid_r <= {owner_r, ~owner_r};
          state_r     <= IDLE;
        end
        ERR: begin
          rsp_valid_r <= {owner_r, ~owner_r};
          rsp_err_r   <= 1'b1;
          state_r     <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // store data is only presented while writing
  always_comb begin
    if (state_r == WR) begin
      mem_wdata_s = (size_r == SZ_W) ? wdata_r : merged_r;
    end else begin
      mem_wdata_s = 32'd0;
    end
  end

  assign mem_read  = (state_r == RD);
  assign mem_write = (state_r == WR);
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
